// File: rtl/nor_response_checker.sv
// nor_response_checker
// Drives nothing itself. It watches the vectors applied to a 2-input NOR
// device and samples that device's output a fixed number of cycles later.
// For each run it keeps a count of vectors, a count of mismatches, a coverage
// map of the input combinations seen, and the first failing vector.
//
// Parameters
//   SETTLE : cycles from vector capture to sampling y (1..15)
//   NVEC   : vectors checked per run (1..255)
//
// Ports
//   clk            : clock; all state changes on the rising edge
//   rst            : synchronous, active-high reset
//   start          : begin a run (accepted in IDLE or DONE)
//   x_valid        : x1/x2 carry a new vector this cycle
//   x1, x2         : vector applied to the NOR device
//   y              : output of the NOR device under check
//   busy           : run in progress (WAIT or SETTLE)
//   done           : run complete, results stable
//   pass           : in DONE with no errors and full coverage
//   vec_count      : vectors checked this run
//   err_count      : mismatches this run, saturating at 255
//   cov_map        : bit {x1,x2} set once that combination was checked
//   first_fail     : {x1,x2,y} of the first mismatching vector
//   first_fail_vld : first_fail holds a captured vector
module nor_response_checker #(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned NVEC   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       x_valid,
   input  logic       x1,
   input  logic       x2,
   input  logic       y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] vec_count,
   output logic [7:0] err_count,
   output logic [3:0] cov_map,
   output logic [2:0] first_fail,
   output logic       first_fail_vld
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SETTLE,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
   localparam logic [7:0] NVEC_L      = 8'(NVEC);

   state_t     state;
   state_t     state_next;
   logic [1:0] x_reg;
   logic [3:0] settle_cnt;
   logic       start_run;
   logic       capture;
   logic       sample;
   logic       expected;
   logic       mismatch;
   logic [7:0] vec_next;

   assign expected = ~(x_reg[1] | x_reg[0]);
   // Case inequality so that an X or Z on y is reported as a mismatch in
   // simulation instead of silently comparing equal.
   assign mismatch = (y !== expected);
   assign vec_next = vec_count + 8'd1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      start_run  = 1'b0;
      capture    = 1'b0;
      sample     = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            // x_valid is deliberately ignored here, even alongside start.
            if (start) begin
               start_run  = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (x_valid) begin
               capture    = 1'b1;
               state_next = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle_cnt == 4'd0) begin
               sample     = 1'b1;
               state_next = (vec_next == NVEC_L) ? S_DONE : S_WAIT;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_reg          <= 2'b00;
         settle_cnt     <= 4'd0;
         vec_count      <= 8'd0;
         err_count      <= 8'd0;
         cov_map        <= 4'd0;
         first_fail     <= 3'd0;
         first_fail_vld <= 1'b0;
      end else begin
         if (start_run) begin
            vec_count      <= 8'd0;
            err_count      <= 8'd0;
            cov_map        <= 4'd0;
            first_fail     <= 3'd0;
            first_fail_vld <= 1'b0;
         end

         // The vector is frozen at capture; x1/x2 are not looked at again
         // until the next WAIT.
         if (capture) begin
            x_reg      <= {x1, x2};
            settle_cnt <= SETTLE_LOAD;
         end else if (state == S_SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end

         if (sample) begin
            vec_count      <= vec_next;
            cov_map[x_reg] <= 1'b1;
            if (mismatch) begin
               if (err_count != 8'hFF) err_count <= err_count + 8'd1;
               if (!first_fail_vld) begin
                  first_fail     <= {x_reg, y};
                  first_fail_vld <= 1'b1;
               end
            end
         end
      end
   end

   assign busy = (state == S_WAIT) || (state == S_SETTLE);
   assign done = (state == S_DONE);
   assign pass = done && (err_count == 8'd0) && (cov_map == 4'hF);

endmodule

// File: tb/tb_nor_response_checker.sv
// Self-checking bench for nor_response_checker (SETTLE=2, NVEC=4).
// A table of hand-computed vectors drives four complete runs; directed
// sequences then cover settle timing, reset mid-run and control corners.
module tb_nor_response_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       x_valid;
   logic       x1;
   logic       x2;
   logic       y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] vec_count;
   logic [7:0] err_count;
   logic [3:0] cov_map;
   logic [2:0] first_fail;
   logic       first_fail_vld;

   int total = 0;
   int bad   = 0;

   nor_response_checker #(.SETTLE(2), .NVEC(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .x_valid        (x_valid),
      .x1             (x1),
      .x2             (x2),
      .y              (y),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .vec_count      (vec_count),
      .err_count      (err_count),
      .cov_map        (cov_map),
      .first_fail     (first_fail),
      .first_fail_vld (first_fail_vld)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       x1;
      logic       x2;
      logic       y;
      logic [7:0] e_vec;
      logic [7:0] e_err;
      logic [3:0] e_cov;
      logic       e_done;
      logic       e_pass;
      logic       e_ffv;
      logic [2:0] e_ff;
   } vec_t;

   vec_t tbl [16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Capture a vector in WAIT, disturb x1/x2 while settling, and present
   // y_final only on the sampling cycle (y_early before that).
   task automatic apply_vec(input logic a, input logic b, input logic y_early, input logic y_final);
      x1 = a; x2 = b; y = y_early; x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      x1 = ~a; x2 = ~b;
      tick();
      y = y_final;
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " done"}, 32'(done), 0);
      check({tag, " pass"}, 32'(pass), 0);
      check({tag, " vec"}, 32'(vec_count), 0);
      check({tag, " err"}, 32'(err_count), 0);
      check({tag, " cov"}, 32'(cov_map), 0);
      check({tag, " ff"}, 32'(first_fail), 0);
      check({tag, " ffv"}, 32'(first_fail_vld), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Run A: correct device
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 4'h1, 1'b0, 1'b0, 1'b0, 3'b000};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 4'h3, 1'b0, 1'b0, 1'b0, 3'b000};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 4'h7, 1'b0, 1'b0, 1'b0, 3'b000};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'd4, 8'd0, 4'hF, 1'b1, 1'b1, 1'b0, 3'b000};
      // Run B: y stuck at 0
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 4'h1, 1'b0, 1'b0, 1'b1, 3'b000};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd2, 8'd1, 4'h3, 1'b0, 1'b0, 1'b1, 3'b000};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 4'h7, 1'b0, 1'b0, 1'b1, 3'b000};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'd4, 8'd1, 4'hF, 1'b1, 1'b0, 1'b1, 3'b000};
      // Run C: incomplete coverage, all correct
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 4'h1, 1'b0, 1'b0, 1'b0, 3'b000};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd2, 8'd0, 4'h1, 1'b0, 1'b0, 1'b0, 3'b000};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 4'h3, 1'b0, 1'b0, 1'b0, 3'b000};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 8'd4, 8'd0, 4'hB, 1'b1, 1'b0, 1'b0, 3'b000};
      // Run D: y stuck at 1, first failure is 01 -> {0,1,1}
      tbl[12] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 4'h1, 1'b0, 1'b0, 1'b0, 3'b000};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 8'd2, 8'd1, 4'h3, 1'b0, 1'b0, 1'b1, 3'b011};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 8'd3, 8'd2, 4'h7, 1'b0, 1'b0, 1'b1, 3'b011};
      tbl[15] = '{1'b1, 1'b1, 1'b1, 8'd4, 8'd3, 4'hF, 1'b1, 1'b0, 1'b1, 3'b011};

      rst = 1'b1; start = 1'b0; x_valid = 1'b0; x1 = 1'b0; x2 = 1'b0; y = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_all_zero("reset");

      // Table-driven runs
      for (int i = 0; i < 16; i++) begin
         if (i % 4 == 0) begin
            do_start();
            check($sformatf("tbl[%0d] start vec", i), 32'(vec_count), 0);
            check($sformatf("tbl[%0d] start busy", i), 32'(busy), 1);
         end
         apply_vec(tbl[i].x1, tbl[i].x2, tbl[i].y, tbl[i].y);
         check($sformatf("tbl[%0d] vec", i), 32'(vec_count), 32'(tbl[i].e_vec));
         check($sformatf("tbl[%0d] err", i), 32'(err_count), 32'(tbl[i].e_err));
         check($sformatf("tbl[%0d] cov", i), 32'(cov_map), 32'(tbl[i].e_cov));
         check($sformatf("tbl[%0d] done", i), 32'(done), 32'(tbl[i].e_done));
         check($sformatf("tbl[%0d] pass", i), 32'(pass), 32'(tbl[i].e_pass));
         check($sformatf("tbl[%0d] ffv", i), 32'(first_fail_vld), 32'(tbl[i].e_ffv));
         check($sformatf("tbl[%0d] ff", i), 32'(first_fail), 32'(tbl[i].e_ff));
      end

      // Settle timing: y wrong at capture and one cycle later, right at sample
      do_start();
      apply_vec(1'b0, 1'b0, 1'b0, 1'b1);
      apply_vec(1'b0, 1'b1, 1'b1, 1'b0);
      apply_vec(1'b1, 1'b0, 1'b1, 1'b0);
      apply_vec(1'b1, 1'b1, 1'b1, 1'b0);
      check("glitch err", 32'(err_count), 0);
      check("glitch done", 32'(done), 1);
      check("glitch pass", 32'(pass), 1);

      // Reset while settling the third vector of a run
      do_start();
      apply_vec(1'b0, 1'b0, 1'b1, 1'b1);
      apply_vec(1'b0, 1'b1, 1'b0, 1'b0);
      x1 = 1'b1; x2 = 1'b0; y = 1'b0; x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      check("midrun busy", 32'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("midrun rst");
      do_start();
      apply_vec(1'b0, 1'b0, 1'b1, 1'b1);
      apply_vec(1'b0, 1'b1, 1'b0, 1'b0);
      apply_vec(1'b1, 1'b0, 1'b0, 1'b0);
      apply_vec(1'b1, 1'b1, 1'b0, 1'b0);
      check("after rst pass", 32'(pass), 1);
      check("after rst vec", 32'(vec_count), 4);

      // x_valid held high through SETTLE with a different vector on x1/x2
      do_start();
      x1 = 1'b0; x2 = 1'b0; y = 1'b1; x_valid = 1'b1;
      tick();
      x1 = 1'b1; x2 = 1'b1;
      tick();
      tick();
      x_valid = 1'b0;
      check("xv settle vec", 32'(vec_count), 1);
      check("xv settle cov", 32'(cov_map), 1);
      check("xv settle err", 32'(err_count), 0);

      // start ignored in WAIT
      do_start();
      check("start in wait vec", 32'(vec_count), 1);
      check("start in wait busy", 32'(busy), 1);
      apply_vec(1'b0, 1'b1, 1'b0, 1'b0);
      apply_vec(1'b1, 1'b0, 1'b0, 1'b0);
      apply_vec(1'b1, 1'b1, 1'b0, 1'b0);
      check("ctl run done", 32'(done), 1);
      check("ctl run pass", 32'(pass), 1);

      // x_valid ignored in DONE; results held
      x1 = 1'b0; x2 = 1'b0; y = 1'b0; x_valid = 1'b1;
      tick();
      tick();
      x_valid = 1'b0;
      check("done hold vec", 32'(vec_count), 4);
      check("done hold cov", 32'(cov_map), 15);
      check("done hold pass", 32'(pass), 1);

      // start with x_valid in DONE: start only
      start = 1'b1; x_valid = 1'b1;
      tick();
      start = 1'b0; x_valid = 1'b0;
      check("start+xv vec", 32'(vec_count), 0);
      check("start+xv cov", 32'(cov_map), 0);
      check("start+xv busy", 32'(busy), 1);
      check("start+xv done", 32'(done), 0);
      tick();
      tick();
      tick();
      check("start+xv dropped vec", 32'(vec_count), 0);

      // rst wins over start and x_valid
      rst = 1'b1; start = 1'b1; x_valid = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; x_valid = 1'b0;
      tick();
      check_all_zero("rst prio");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nor_response_checker.md
NOR_RESPONSE_CHECKER -- requirements
Module: nor_response_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the cycles waited after vector capture before sampling y (legal range 1..15).
REQ-002 The block SHALL have parameter NVEC, default 4, giving the vectors checked per run (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begins a run, accepted in IDLE or DONE.
REQ-006 The block SHALL have port x_valid, input, 1 bit: x1/x2 carry a new vector this cycle.
REQ-007 The block SHALL have ports x1 and x2, input, 1 bit each: the vector applied to the NOR DUT.
REQ-008 The block SHALL have port y, input, 1 bit: the DUT output under check.
REQ-009 The block SHALL have port busy, output, 1 bit: high in WAIT or SETTLE.
REQ-010 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-011 The block SHALL have port pass, output, 1 bit: high in DONE only when err_count==0 and cov_map==4'hF.
REQ-012 The block SHALL have port vec_count, output, 8 bits: vectors checked this run.
REQ-013 The block SHALL have port err_count, output, 8 bits: mismatches this run, saturating at 255.
REQ-014 The block SHALL have port cov_map, output, 4 bits: bit {x1,x2} set once that combination has been checked.
REQ-015 The block SHALL have port first_fail, output, 3 bits: {x1,x2,y} of the first mismatching vector.
REQ-016 The block SHALL have port first_fail_vld, output, 1 bit: first_fail holds a captured vector.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT, SETTLE and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL clear vec_count, err_count, cov_map, first_fail and first_fail_vld, then enter WAIT on the next cycle.
REQ-019 In WAIT, x_valid=1 SHALL register x1/x2, load the settle counter with SETTLE-1, and enter SETTLE; x_valid=0 SHALL hold WAIT.
REQ-020 In SETTLE, the counter SHALL decrement each cycle, and y SHALL be sampled on the cycle the counter reads 0, i.e. SETTLE cycles after capture.
REQ-021 At sample, expected SHALL be ~(x1|x2) of the registered vector; any y value not identical to expected (including X or Z in simulation) SHALL count as a mismatch.
REQ-022 At sample: vec_count SHALL increment, cov_map[{x1,x2}] SHALL be set, and on a mismatch err_count SHALL increment (saturating at 255).
REQ-023 The first mismatch of a run SHALL load first_fail and set first_fail_vld; later mismatches SHALL leave both unchanged.
REQ-024 After a sample, the FSM SHALL enter DONE when the new vec_count equals NVEC, otherwise WAIT.
REQ-025 x_valid SHALL be ignored in SETTLE, DONE and IDLE, and changes on x1/x2 during SETTLE SHALL not affect the registered vector.
REQ-026 start SHALL be ignored in WAIT and SETTLE.
REQ-027 DONE SHALL hold all result outputs stable until start or rst.
REQ-028 start and x_valid asserted together in DONE SHALL act as start only; that x_valid SHALL be dropped.
REQ-029 pass SHALL be 0 outside DONE.
REQ-030 If NVEC is below 4, pass SHALL still require full coverage and therefore SHALL be 0.

Reset
REQ-031 rst=1 SHALL force IDLE and zero busy, done, pass, vec_count, err_count, cov_map, first_fail, first_fail_vld and the settle counter on the next edge, from any state.
REQ-032 rst SHALL take priority over start and x_valid in the same cycle.
REQ-033 A run interrupted by rst SHALL leave no residual results.

Verification
REQ-034 Correct DUT: start, then vectors 00, 01, 10, 11 with y = 1, 0, 0, 0 -> done=1, pass=1, vec_count=4, err_count=0, cov_map=F, first_fail_vld=0.
REQ-035 Faulty DUT with y stuck at 0 -> vector 00 mismatches -> err_count=1, first_fail=3'b000, first_fail_vld=1, pass=0.
REQ-036 Timing: with SETTLE=2, y correct only from 2 cycles after capture -> no error; y glitching in the cycle after capture -> no error recorded.
REQ-037 Coverage: vectors 00, 00, 01, 11 all correct -> done=1, err_count=0, cov_map=4'b1011, pass=0.
REQ-038 Reset mid-run: rst asserted in SETTLE after 2 vectors -> next cycle IDLE, all outputs 0; a new start followed by 4 correct vectors -> pass=1.
REQ-039 Control corner cases: x_valid pulsed during SETTLE -> vec_count advances by one only; start plus x_valid in DONE -> counters clear, vec_count=0 in WAIT.
